spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: register address width, equal to the SPI slave address field.
REQ-002 Parameter DATA_WIDTH, default 24: register width, equal to the SPI slave data field.
REQ-003 Parameter NUM_CTRL, default 8, range 1..16: number of writable control registers.
REQ-004 Parameter NUM_STAT, default 8, range 1..16: number of read-only status registers.
REQ-005 Parameter ID_VALUE, default 24'h564E41: constant returned at address 0x00.
REQ-006 Port clk, input, 1: the only clock; reset is synchronous and active-low.
REQ-007 Port nrst, input, 1: synchronous active-low reset.
REQ-008 Port addr, input, ADDR_WIDTH: frame address from the SPI slave.
REQ-009 Port addr_ready, input, 1: address valid; stays high until the frame completes or is aborted.
REQ-010 Port rw, input, 1: 1 = read, 0 = write; valid while addr_ready is high.
REQ-011 Port wr_data, input, DATA_WIDTH: received data; valid while data_ready is high.
REQ-012 Port data_ready, input, 1: frame fully received.
REQ-013 Port rd_data, output, DATA_WIDTH: read data returned to the SPI slave for shift-out.
REQ-014 Port status_in, input, NUM_STAT*DATA_WIDTH: packed status words; word i is at address 0x20+i.
REQ-015 Port ctrl_regs, output, NUM_CTRL*DATA_WIDTH: packed control registers; word i is at address 0x10+i.
REQ-016 Port ctrl_update, output, NUM_CTRL: one-cycle pulse on bit i when ctrl word i is written.
REQ-017 Port cmd_pulse, output, 8: one-cycle command strobes.
REQ-018 Port err_irq, output, 1: OR of all FLAGS bits.

Function
REQ-019 Address map: 0x00 ID (RO); 0x01 FLAGS (W1C); 0x02 CMD (WO, reads 0); 0x03 SCRATCH (RW); 0x10+i CTRL; 0x20+i STAT (RO); every other address is unmapped and reads 0.
REQ-020 FSM states: IDLE, LOOKUP, WAIT_DATA, DONE.
REQ-021 IDLE: when an addr_ready rising edge is detected (registered copy is 0, input is 1), the block shall capture addr and rw and go to LOOKUP.
REQ-022 LOOKUP: the block shall register rd_data from the captured address, sampling status_in in this cycle, then go to WAIT_DATA; rd_data is valid 2 clk after the addr_ready rise and holds until the next capture.
REQ-023 WAIT_DATA: on data_ready=1 with captured rw=0, the block shall commit the write to its target, then go to DONE.
REQ-024 WAIT_DATA: on data_ready=1 with captured rw=1, the block shall write nothing, then go to DONE.
REQ-025 WAIT_DATA: if addr_ready=0 while data_ready=0, the frame is aborted: no write, set FLAGS[2], go to IDLE.
REQ-026 DONE: the block shall return to IDLE when addr_ready=0 and data_ready=0, which allows back-to-back frames within one chip-select.
REQ-027 Commit timing: the target register takes wr_data at the clk edge ending the commit cycle; ctrl_update and cmd_pulse are asserted for exactly the following cycle.
REQ-028 CMD write: cmd_pulse shall equal wr_data[7:0] for one cycle; higher bits are ignored.
REQ-029 FLAGS write: each bit written 1 clears that flag; if a set and a clear hit the same bit in the same cycle, set wins.
REQ-030 FLAGS[0] shall be set on a write to a RO or unmapped address; the write is dropped.
REQ-031 FLAGS[1] shall be set on a read from an unmapped address.
REQ-032 Out-of-range CTRL/STAT indices (i >= NUM_CTRL or i >= NUM_STAT) are unmapped.

Reset
REQ-033 When nrst=0 at a clk edge, the block shall set: state IDLE, ctrl_regs to 0, SCRATCH 0, FLAGS 0, rd_data 0, ctrl_update 0, cmd_pulse 0, err_irq 0, edge-detect registers 0.
REQ-034 A reset asserted mid-frame shall discard that frame; after release, the block shall accept no frame until a fresh addr_ready rising edge.

Structure
REQ-035 A shared package spi_regs_pkg shall hold the address constants, FLAGS bit indices, the CMD field width and the FSM state type.
REQ-036 The design shall have one sub-module, spi_reg_decode: a combinational classifier mapping an address to {kind, index, writable, mapped}.

Verification
REQ-037 Write 0x10 = 0x123456, then read 0x10 -> ctrl_regs word0 = 0x123456, ctrl_update = 0x01 for 1 cycle, read returns 0x123456.
REQ-038 Read 0x00 -> rd_data = 0x564E41 within 2 clk of the addr_ready rise; no state change.
REQ-039 Write 0x02 = 0x000005 -> cmd_pulse = 0x05 for exactly 1 cycle, then 0x00.
REQ-040 Write 0x20 = 0xFFFFFF -> status unchanged, FLAGS = 0b001, err_irq = 1; write 0x01 = 0x000001 -> FLAGS = 0, err_irq = 0.
REQ-041 Drop addr_ready without data_ready during a write to 0x11 -> ctrl word1 unchanged, FLAGS[2] = 1, FSM in IDLE.
REQ-042 Two back-to-back frames in one chip-select (write 0x03 = 0xA5A5A5, read 0x03), with nrst pulsed low mid-third-frame -> second read returns 0xA5A5A5, all outputs 0 after reset.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register controller: address map, FLAGS bits,
// command field width, FSM state and register-kind encodings.
package spi_regs_pkg;

    localparam int unsigned AddrId       = 32'h00;
    localparam int unsigned AddrFlags    = 32'h01;
    localparam int unsigned AddrCmd      = 32'h02;
    localparam int unsigned AddrScratch  = 32'h03;
    localparam int unsigned AddrCtrlBase = 32'h10;
    localparam int unsigned AddrStatBase = 32'h20;

    localparam int unsigned FlagWrErr = 0;
    localparam int unsigned FlagRdErr = 1;
    localparam int unsigned FlagAbort = 2;
    localparam int unsigned NumFlags  = 3;

    localparam int unsigned CmdWidth = 8;

    typedef enum logic [1:0] {StIdle, StLookup, StWaitData, StDone} state_t;

    typedef enum logic [2:0] {
        KindNone, KindId, KindFlags, KindCmd, KindScratch, KindCtrl, KindStat
    } reg_kind_t;

endpackage

// File: rtl/spi_reg_decode.sv
// Combinational address classifier: maps a register address to its kind,
// word index within a bank, and whether it is mapped and writable.
module spi_reg_decode
    import spi_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NUM_CTRL   = 8,
    parameter int unsigned NUM_STAT   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output reg_kind_t             kind,
    output logic [3:0]            index,
    output logic                  writable,
    output logic                  mapped
);

    logic [31:0] a;

    always_comb begin
        a        = 32'(addr);
        kind     = KindNone;
        index    = a[3:0];
        if (a == AddrId) begin
            kind = KindId;
        end else if (a == AddrFlags) begin
            kind = KindFlags;
        end else if (a == AddrCmd) begin
            kind = KindCmd;
        end else if (a == AddrScratch) begin
            kind = KindScratch;
        end else if ((a >> 4) == (AddrCtrlBase >> 4) && 32'(a[3:0]) < NUM_CTRL) begin
            kind = KindCtrl;
        end else if ((a >> 4) == (AddrStatBase >> 4) && 32'(a[3:0]) < NUM_STAT) begin
            kind = KindStat;
        end
        mapped   = (kind != KindNone);
        writable = (kind == KindFlags) || (kind == KindCmd) ||
                   (kind == KindScratch) || (kind == KindCtrl);
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register file behind an SPI slave: frame FSM, ID/FLAGS/CMD/SCRATCH registers,
// a bank of control registers and a window onto external status words.
module spi_reg_ctrl
    import spi_regs_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 7,
    parameter int unsigned          DATA_WIDTH = 24,
    parameter int unsigned          NUM_CTRL   = 8,
    parameter int unsigned          NUM_STAT   = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 24'h564E41
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           addr_ready,
    input  logic                           rw,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           data_ready,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] status_in,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]            ctrl_update,
    output logic [CmdWidth-1:0]            cmd_pulse,
    output logic                           err_irq
);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic                    addr_ready_q;
    logic                    armed;
    logic [DATA_WIDTH-1:0]   scratch;
    logic [NumFlags-1:0]     flags;
    logic [NumFlags-1:0]     flag_set;
    logic [NumFlags-1:0]     flag_clr;
    logic [DATA_WIDTH-1:0]   rd_next;

    reg_kind_t  kind;
    logic [3:0] index;
    logic       writable;
    logic       mapped;

    spi_reg_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_CTRL   (NUM_CTRL),
        .NUM_STAT   (NUM_STAT)
    ) u_decode (
        .addr     (addr_q),
        .kind     (kind),
        .index    (index),
        .writable (writable),
        .mapped   (mapped)
    );

    always_comb begin
        rd_next = '0;
        case (kind)
            KindId:      rd_next = ID_VALUE;
            KindFlags:   rd_next = DATA_WIDTH'(flags);
            KindScratch: rd_next = scratch;
            KindCtrl:    rd_next = ctrl_regs[32'(index)*DATA_WIDTH +: DATA_WIDTH];
            KindStat:    rd_next = status_in[32'(index)*DATA_WIDTH +: DATA_WIDTH];
            default:     rd_next = '0;
        endcase
    end

    // Flag sources and W1C clears; merged below so a same-cycle set beats a clear.
    always_comb begin
        flag_set = '0;
        flag_clr = '0;
        case (state)
            StLookup: begin
                if (rw_q && !mapped) flag_set[FlagRdErr] = 1'b1;
            end
            StWaitData: begin
                if (data_ready) begin
                    if (!rw_q && !writable) flag_set[FlagWrErr] = 1'b1;
                    else if (!rw_q && kind == KindFlags) flag_clr = wr_data[NumFlags-1:0];
                end else if (!addr_ready) begin
                    flag_set[FlagAbort] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign err_irq = |flags;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= StIdle;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            addr_ready_q <= 1'b0;
            armed        <= 1'b0;
            scratch      <= '0;
            flags        <= '0;
            rd_data      <= '0;
            ctrl_regs    <= '0;
            ctrl_update  <= '0;
            cmd_pulse    <= '0;
        end else begin
            addr_ready_q <= addr_ready;
            // A frame still open across reset must see addr_ready low before a new capture.
            if (!addr_ready) armed <= 1'b1;
            ctrl_update  <= '0;
            cmd_pulse    <= '0;
            flags        <= (flags & ~flag_clr) | flag_set;
            case (state)
                StIdle: begin
                    if (armed && addr_ready && !addr_ready_q) begin
                        addr_q <= addr;
                        rw_q   <= rw;
                        state  <= StLookup;
                    end
                end
                StLookup: begin
                    rd_data <= rd_next;
                    state   <= StWaitData;
                end
                StWaitData: begin
                    if (data_ready) begin
                        if (!rw_q && writable) begin
                            case (kind)
                                KindScratch: scratch <= wr_data;
                                KindCmd:     cmd_pulse <= wr_data[CmdWidth-1:0];
                                KindCtrl: begin
                                    ctrl_regs[32'(index)*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                                    ctrl_update <= NUM_CTRL'(1) << index;
                                end
                                default: ;
                            endcase
                        end
                        state <= StDone;
                    end else if (!addr_ready) begin
                        state <= StIdle;
                    end
                end
                StDone: begin
                    if (!addr_ready && !data_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
